kamacore_fetch: RTL

//  Instruction fetch stage feeding decode; sole driver of the program memory's dual (read-only) port.

---
 rtl/kamacore_pkg.sv | 18 +
 rtl/kamacore_fetch_fifo.sv | 66 ++++++
 rtl/kamacore_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/kamacore_pkg.sv
// Shared kamacore types and widths.
// The fetch entry pairs an instruction word with the word address it came from.
package kamacore_pkg;

    localparam int CPU_WIDTH  = 16;
    localparam int ADDR_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0]  instr;
    } fetch_entry_t;

    // Count width able to hold 0..depth inclusive.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : kamacore_pkg

// File: rtl/kamacore_fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between fetch and decode.
// Head is read straight from storage, so it carries no combinational input dependency.
module kamacore_fetch_fifo
    import kamacore_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = fifo_count_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left alone; only the bookkeeping is discarded.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : kamacore_fetch_fifo

// File: rtl/kamacore_fetch.sv
// Instruction fetch stage: PC, program-memory read port, prefetch FIFO and redirect handling.
// Define KAMACORE_FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module kamacore_fetch
    import kamacore_pkg::*;
#(
    parameter int                    MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int                    FIFO_DEPTH     = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_en,
    output logic [MEM_ADDR_WIDTH-1:0] dpra,
    input  logic [CPU_WIDTH-1:0]      dpo,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [CPU_WIDTH-1:0]      instr,
    output logic [ADDR_WIDTH-1:0]     instr_pc
`ifdef KAMACORE_FETCH_PERF_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_stall
`endif
);

    localparam int              CW      = fifo_count_width(FIFO_DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    fetch_entry_t          head;
    fetch_entry_t          push_data;
    logic                  push;
    logic                  pop;

    // Decode handshake: an entry transfers on any clock edge where instr_valid and
    // instr_ready are both high. instr_valid/instr/instr_pc depend only on registered
    // state; instr_ready may only influence whether a new fetch is taken this cycle.
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    assign pop  = instr_valid & instr_ready;
    assign push = fetch_en & ~redirect_valid & ((count != DEPTH_C) | pop);

    // The memory port is narrower than or equal to the PC; high PC bits are dropped.
    assign dpra = pc[MEM_ADDR_WIDTH-1:0];

    assign push_data.pc    = pc;
    assign push_data.instr = dpo;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

    kamacore_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

`ifdef KAMACORE_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (instr_valid & ~instr_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule : kamacore_fetch
